// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, format codes and the decoded control payload.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned OPC_W        = 7;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        fmt_e             fmt;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_we;
        logic             illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I field and immediate decode; unused indices are forced to zero.
module decode_comb
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output dec_ctrl_t       ctrl
);

    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd_f;
    logic [REG_W-1:0]  rs1_f;
    logic [REG_W-1:0]  rs2_f;
    logic signed [31:0] imm32;

    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];

    always_comb begin
        ctrl         = '0;
        ctrl.fmt     = FMT_ILLEGAL;
        ctrl.illegal = 1'b1;
        imm32        = '0;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OP_R: begin
                    ctrl.fmt      = FMT_R;
                    ctrl.illegal  = 1'b0;
                    ctrl.rs1      = rs1_f;
                    ctrl.rs2      = rs2_f;
                    ctrl.rd       = rd_f;
                    ctrl.rs1_used = 1'b1;
                    ctrl.rs2_used = 1'b1;
                    ctrl.rd_we    = (rd_f != 5'd0);
                end
                OP_IMM, OP_LOAD, OP_JALR: begin
                    ctrl.fmt      = FMT_I;
                    ctrl.illegal  = 1'b0;
                    ctrl.rs1      = rs1_f;
                    ctrl.rd       = rd_f;
                    ctrl.rs1_used = 1'b1;
                    ctrl.rd_we    = (rd_f != 5'd0);
                    imm32         = {{20{instr[31]}}, instr[31:20]};
                end
                OP_STORE: begin
                    ctrl.fmt      = FMT_S;
                    ctrl.illegal  = 1'b0;
                    ctrl.rs1      = rs1_f;
                    ctrl.rs2      = rs2_f;
                    ctrl.rs1_used = 1'b1;
                    ctrl.rs2_used = 1'b1;
                    imm32         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OP_BRANCH: begin
                    ctrl.fmt      = FMT_B;
                    ctrl.illegal  = 1'b0;
                    ctrl.rs1      = rs1_f;
                    ctrl.rs2      = rs2_f;
                    ctrl.rs1_used = 1'b1;
                    ctrl.rs2_used = 1'b1;
                    imm32         = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    ctrl.fmt      = FMT_U;
                    ctrl.illegal  = 1'b0;
                    ctrl.rd       = rd_f;
                    ctrl.rd_we    = (rd_f != 5'd0);
                    imm32         = {instr[31:12], 12'b0};
                end
                OP_JAL: begin
                    ctrl.fmt      = FMT_J;
                    ctrl.illegal  = 1'b0;
                    ctrl.rd       = rd_f;
                    ctrl.rd_we    = (rd_f != 5'd0);
                    imm32         = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Signed source makes the width cast sign-extend above bit 31 for XLEN=64.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a DEPTH-entry in-order output FIFO with valid/ready handshake.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] dec_imm;
    dec_ctrl_t       dec_ctrl;

    decode_comb #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .ctrl  (dec_ctrl)
    );

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] imm_mem  [DEPTH];
    dec_ctrl_t       ctrl_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          valid_q;
    logic          ready_q;
    logic          push;
    logic          pop;

    // Handshake qualifiers come from registered flags only; flush masks both sides.
    assign push = in_valid && ready_q && !flush;
    assign pop  = valid_q && out_ready && !flush;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Occupancy, pointers and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);
            ready_q <= (count_nxt < CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                imm_mem[i]  <= '0;
                ctrl_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            imm_mem[wr_ptr]  <= dec_imm;
            ctrl_mem[wr_ptr] <= dec_ctrl;
        end
    end

    dec_ctrl_t head_ctrl;

    assign head_ctrl    = valid_q ? ctrl_mem[rd_ptr] : '0;
    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign out_pc       = valid_q ? pc_mem[rd_ptr]  : '0;
    assign out_imm      = valid_q ? imm_mem[rd_ptr] : '0;
    assign out_rs1      = head_ctrl.rs1;
    assign out_rs2      = head_ctrl.rs2;
    assign out_rd       = head_ctrl.rd;
    assign out_fmt      = head_ctrl.fmt;
    assign out_rs1_used = head_ctrl.rs1_used;
    assign out_rs2_used = head_ctrl.rs2_used;
    assign out_rd_we    = head_ctrl.rd_we;
    assign out_illegal  = head_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: XLEN=64 and XLEN=32 instances driven in lockstep.
module tb_decode_stage;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        rdy64, vld64, u1_64, u2_64, we64, ill64;
    logic [63:0] pc64, imm64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [2:0]  fmt64;

    logic        rdy32, vld32, u1_32, u2_32, we32, ill32;
    logic [31:0] pc32, imm32;
    logic [4:0]  rs1_32, rs2_32, rd_32;
    logic [2:0]  fmt32;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(vld64), .out_ready(out_ready), .out_pc(pc64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd_64), .out_imm(imm64), .out_fmt(fmt64),
        .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_rd_we(we64), .out_illegal(ill64)
    );

    decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(vld32), .out_ready(out_ready), .out_pc(pc32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd_32), .out_imm(imm32), .out_fmt(fmt32),
        .out_rs1_used(u1_32), .out_rs2_used(u2_32), .out_rd_we(we32), .out_illegal(ill32)
    );

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  fmt;
        logic        rs1u;
        logic        rs2u;
        logic        we;
        logic        ill;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        rs1u;
        logic        rs2u;
        logic        we;
        logic        ill;
    } dec_t;

    typedef struct {
        dec_t        d;
        logic [63:0] pc;
    } ent_t;

    int n_cmp = 0;
    int n_fail = 0;
    ent_t q[$];
    bit m_en = 1'b0;
    int unsigned ops[9] = '{51, 19, 3, 103, 35, 99, 55, 23, 111};
    dec_t vecs[11];

    function automatic longint fld(logic [31:0] ins, int lo, int w);
        longint u;
        u = longint'({32'b0, ins});
        return (u >> lo) & ((64'sd1 << w) - 64'sd1);
    endfunction

    // Reference decoder: format table by opcode value, immediates assembled arithmetically.
    function automatic dec_t ref_dec(logic [31:0] ins);
        dec_t d;
        longint sgn;
        longint op;
        bit uses1, uses2, writes;
        d = '{ins, 5'd0, 5'd0, 5'd0, 64'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        sgn = ins[31] ? -64'sd1 : 64'sd0;
        op = fld(ins, 0, 7);
        uses1 = 0; uses2 = 0; writes = 0;
        case (op)
            51:          begin d.fmt = 3'd0; uses1 = 1; uses2 = 1; writes = 1; end
            19, 3, 103:  begin d.fmt = 3'd1; uses1 = 1; writes = 1; d.imm = (sgn << 12) | fld(ins, 20, 12); end
            35:          begin d.fmt = 3'd2; uses1 = 1; uses2 = 1;
                               d.imm = (sgn << 12) | (fld(ins, 25, 7) << 5) | fld(ins, 7, 5); end
            99:          begin d.fmt = 3'd3; uses1 = 1; uses2 = 1;
                               d.imm = (sgn << 12) | (fld(ins, 7, 1) << 11) | (fld(ins, 25, 6) << 5) | (fld(ins, 8, 4) << 1); end
            55, 23:      begin d.fmt = 3'd4; writes = 1; d.imm = (sgn << 32) | (fld(ins, 12, 20) << 12); end
            111:         begin d.fmt = 3'd5; writes = 1;
                               d.imm = (sgn << 20) | (fld(ins, 12, 8) << 12) | (fld(ins, 20, 1) << 11) | (fld(ins, 21, 10) << 1); end
            default: ;
        endcase
        if (d.fmt != 3'd7) begin
            d.ill  = 1'b0;
            d.rs1  = uses1  ? 5'(fld(ins, 15, 5)) : 5'd0;
            d.rs2  = uses2  ? 5'(fld(ins, 20, 5)) : 5'd0;
            d.rd   = writes ? 5'(fld(ins, 7, 5))  : 5'd0;
            d.rs1u = uses1;
            d.rs2u = uses2;
            d.we   = writes && (d.rd != 5'd0);
        end
        return d;
    endfunction

    function automatic obs_t dec_to_obs(dec_t d, logic [63:0] pc, bit is32, logic v, logic r);
        obs_t o;
        o = '0;
        o.valid = v;
        o.ready = r;
        if (v) begin
            o.pc   = is32 ? {32'b0, pc[31:0]} : pc;
            o.imm  = is32 ? {32'b0, d.imm[31:0]} : d.imm;
            o.rs1  = d.rs1;
            o.rs2  = d.rs2;
            o.rd   = d.rd;
            o.fmt  = d.fmt;
            o.rs1u = d.rs1u;
            o.rs2u = d.rs2u;
            o.we   = d.we;
            o.ill  = d.ill;
        end
        return o;
    endfunction

    function automatic obs_t exp_obs(bit is32);
        logic r;
        r = m_en && (q.size() < DEPTH);
        if (q.size() != 0) return dec_to_obs(q[0].d, q[0].pc, is32, 1'b1, r);
        return dec_to_obs(q.size() != 0 ? q[0].d : ref_dec(32'h0), 64'd0, is32, 1'b0, r);
    endfunction

    function automatic obs_t obs64();
        return '{vld64, rdy64, pc64, imm64, rs1_64, rs2_64, rd_64, fmt64, u1_64, u2_64, we64, ill64};
    endfunction

    function automatic obs_t obs32();
        return '{vld32, rdy32, {32'b0, pc32}, {32'b0, imm32}, rs1_32, rs2_32, rd_32, fmt32, u1_32, u2_32, we32, ill32};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b r=%b pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d fmt=%0d u1=%b u2=%b we=%b ill=%b ; required v=%b r=%b pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d fmt=%0d u1=%b u2=%b we=%b ill=%b",
                     name, got.valid, got.ready, got.pc, got.imm, got.rs1, got.rs2, got.rd, got.fmt, got.rs1u, got.rs2u, got.we, got.ill,
                     exp.valid, exp.ready, exp.pc, exp.imm, exp.rs1, exp.rs2, exp.rd, exp.fmt, exp.rs1u, exp.rs2u, exp.we, exp.ill);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "/x64"}, obs64(), exp_obs(1'b0));
        check({tag, "/x32"}, obs32(), exp_obs(1'b1));
    endtask

    // One clock of stimulus; the model decides accept/pop from its own pre-edge state.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl, input string tag);
        bit acc, pp;
        ent_t e;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc = iv && m_en && (q.size() < DEPTH) && !fl;
        pp  = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                e.d  = ref_dec(ins);
                e.pc = pc;
                q.push_back(e);
            end
        end
        m_en = 1'b1;
        check_both(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int unsigned sel;
        r = $urandom;
        sel = $urandom_range(0, 10);
        if (sel < 9) r = (r & ~32'h7F) | ops[sel];
        return r;
    endfunction

    initial begin
        vecs[0]  = '{32'hFFF00093, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'hFE208EE3, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h0020A423, 5'd1, 5'd2, 5'd0, 64'h0000_0000_0000_0008, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 64'h0000_0000_1234_5000, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000000, 5'd0, 5'd0, 5'd0, 64'h0,                   3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{32'h80000037, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 64'h0,                   3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFDFF0EF, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'hFFF00092, 5'd0, 5'd0, 5'd0, 64'h0,                   3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000000F, 5'd0, 5'd0, 5'd0, 64'h0,                   3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h00008067, 5'd1, 5'd0, 5'd0, 64'h0,                   3'd1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset: everything zero, in_ready held low until the first edge after release.
        #12;
        check_both("in_reset");
        rst_n = 1'b1;
        #1;
        check_both("post_release_pre_edge");
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, "first_edge");
        check_bit("first_edge_ready", rdy64, 1'b1);

        // Directed decode table: push one, check head against constants, then pop.
        for (int i = 0; i < 11; i++) begin
            logic [63:0] pc;
            pc = 64'h8000_0000_0000_1000 + 64'(i * 4);
            step(1'b1, vecs[i].instr, pc, 1'b0, 1'b0, $sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_x64", i), obs64(), dec_to_obs(vecs[i], pc, 1'b0, 1'b1, 1'b1));
            check($sformatf("vec%0d_x32", i), obs32(), dec_to_obs(vecs[i], pc, 1'b1, 1'b1, 1'b1));
            step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, $sformatf("vec%0d_pop", i));
        end

        // Back-pressure: three offers with out_ready low, then drain in order.
        step(1'b1, 32'h00100093, 64'h100, 1'b0, 1'b0, "bp_a");
        step(1'b1, 32'h00200113, 64'h104, 1'b0, 1'b0, "bp_b");
        check_bit("bp_full_ready", rdy64, 1'b0);
        step(1'b1, 32'h00300193, 64'h108, 1'b0, 1'b0, "bp_c_blocked");
        check_bit("bp_head_is_a", pc64 == 64'h100, 1'b1);
        step(1'b1, 32'h00300193, 64'h108, 1'b1, 1'b0, "bp_pop_a");
        check_bit("bp_head_is_b", pc64 == 64'h104, 1'b1);
        step(1'b1, 32'h00300193, 64'h108, 1'b1, 1'b0, "bp_pop_b_push_c");
        check_bit("bp_head_is_c", pc64 == 64'h108, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, "bp_pop_c");
        check_bit("bp_empty", vld64, 1'b0);

        // Flush with two buffered and a same-cycle offer.
        step(1'b1, 32'h00400213, 64'h200, 1'b0, 1'b0, "fl_fill1");
        step(1'b1, 32'h00500293, 64'h204, 1'b0, 1'b0, "fl_fill2");
        step(1'b1, 32'h00600313, 64'h208, 1'b1, 1'b1, "fl_flush");
        check_bit("fl_valid", vld64, 1'b0);
        check_bit("fl_ready", rdy64, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, "fl_after");

        // Asynchronous reset mid-stream.
        step(1'b1, 32'h00700393, 64'h300, 1'b0, 1'b0, "rs_fill1");
        step(1'b1, 32'h00800413, 64'h304, 1'b0, 1'b0, "rs_fill2");
        #2;
        rst_n = 1'b0;
        q.delete();
        m_en = 1'b0;
        #1;
        check_bit("rs_valid_now", vld64, 1'b0);
        check_both("rs_async");
        #3;
        rst_n = 1'b1;
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, "rs_recover");

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, datapath width (32 or 64)
- DEPTH, 2, output buffer entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts
- out_pc  out  XLEN  address of head entry
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code (see REQ-020)
- out_rs1_used, out_rs2_used, out_rd_we  out  1 each  operand-use and writeback flags
- out_illegal  out  1  unsupported encoding
REQ-003 One clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-004 Opcode map SHALL be: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J.
REQ-005 Any other opcode, or in_instr[1:0]!=2'b11, SHALL set out_illegal=1, with out_imm=0, all used/we flags=0 and indices=0.
REQ-006 Immediates SHALL be built per RV32I bit layouts and sign-extended from in_instr[31] to XLEN; U-type SHALL place instr[31:12] at imm[31:12] with imm[11:0]=0, sign-extended above bit 31 when XLEN=64.
REQ-007 B and J immediates SHALL have bit 0 = 0.
REQ-008 Flags: rs1_used for R/I/S/B; rs2_used for R/S/B; rd_we for R/I/U/J only when rd!=0.
REQ-009 Indices not used by a format SHALL be driven 0, never X.
REQ-010 Decode SHALL be combinational on in_instr and written with in_pc into the buffer on an accept (in_valid && in_ready).
REQ-011 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL present out_valid=1 after edge N.
REQ-012 The buffer SHALL be in-order FIFO of DEPTH entries with a count register; out_* SHALL reflect the head entry, all zero when empty.
REQ-013 in_ready SHALL be (count<DEPTH) from registered state only; there SHALL be no combinational path from out_ready to in_ready.
REQ-014 Pop SHALL occur on out_valid && out_ready.
REQ-015 Simultaneous push and pop with count in 1..DEPTH-1 SHALL leave count unchanged.
REQ-016 With count=0, only push is possible; with count=DEPTH, only pop is possible.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 out_valid SHALL not drop while out_ready=0; head payload SHALL be held stable.
REQ-019 flush SHALL set count=0 at the next edge; an in_valid or out_ready in the same cycle SHALL be ignored, and in_ready SHALL be 1 the following cycle.
REQ-020 out_fmt SHALL be R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7.

Reset
REQ-021 rst_n low SHALL asynchronously clear count, both pointers and all payload registers.
REQ-022 During reset: out_valid=0, in_ready=0; all other outputs SHALL be 0.
REQ-023 in_ready SHALL become 1 on the first edge after rst_n deasserts.
REQ-024 Reset mid-transfer SHALL discard all entries, with no partial output.

Structure
REQ-025 Shared package riscv_pkg SHALL hold the opcode constants, the fmt encoding and the default XLEN.
REQ-026 Combinational decode SHALL be one sub-module, decode_comb; decode_stage adds the FIFO and handshake.

Verification
REQ-027 0xFFF00093 (addi x1,x0,-1) -> rd=1, rs1=0, imm=0xFFFFFFFF, fmt=1, rd_we=1, rs2_used=0.
REQ-028 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, imm=0xFFFFFFFC, fmt=3, rd_we=0; 0x0020A423 (sw x2,8(x1)) -> imm=8, fmt=2.
REQ-029 0x123452B7 (lui x5), XLEN=64 -> imm=0x0000000012345000, rd=5; 0x00000000 -> illegal=1, fmt=7, all flags 0.
REQ-030 out_ready=0, push 3 instructions -> in_ready=0 after 2 accepts; release out_ready -> outputs emerge in order, no loss or duplicate.
REQ-031 flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle instruction absent; rst_n pulsed mid-stream -> out_valid=0 immediately.
